// File: rtl/pf_mem_pkg.sv
// Shared encodings for the fetch/data memory port arbiter: FSM states,
// access attributes and grant identifiers, plus the round-robin pick.
package pf_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_IF_ACC = 2'b01,
      ST_DM_ACC = 2'b10
   } state_e;

   localparam logic       RW_WRITE  = 1'b1;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic       GNT_IF    = 1'b0;
   localparam logic       GNT_DM    = 1'b1;

   // With both requesters eligible the one that did not win last time goes next.
   function automatic logic pick_grant(input logic if_elig, input logic dm_elig,
                                       input logic last_gnt);
      if (if_elig && dm_elig) return (last_gnt == GNT_IF) ? GNT_DM : GNT_IF;
      else if (dm_elig)       return GNT_DM;
      else                    return GNT_IF;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for one memory access: cleared on grant, advanced each
// access cycle, done once the configured number of extra cycles has elapsed.
module mem_wait_counter #(
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 1
) (
   input  logic Clk,
   input  logic R,
   input  logic clr_i,
   input  logic inc_i,
   output logic done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge Clk) begin
      if (R) cnt_q <= '0;
      else   cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// MEM-stage load/store, returning one-cycle valid pulses and pipeline stalls.
module mem_port_arbiter
   import pf_mem_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              R,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_rw,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   input  logic [1:0]        dm_size,
   input  logic              dm_se,
   output logic [31:0]       dm_rdata,
   output logic              dm_valid,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [1:0]        mem_size,
   output logic              mem_se,
   input  logic [31:0]       mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_e            state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic              en_q, en_d, rw_q, rw_d, se_q, se_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
   logic [31:0]       if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic              cnt_clr, cnt_inc, cnt_done, gnt;

   // A requester that completes this cycle is masked so it cannot be re-granted
   // before its pipeline stage has advanced and dropped or renewed the request.
   wire if_elig = if_req & ~if_valid_q;
   wire dm_elig = dm_req & ~dm_valid_q;

   mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) u_wait (
      .Clk    (Clk),
      .R      (R),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .done_o (cnt_done)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      en_d       = en_q;
      rw_d       = rw_q;
      se_d       = se_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      if_valid_d = 1'b0;
      dm_valid_d = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      gnt        = pick_grant(if_elig, dm_elig, last_gnt_q);
      case (state_q)
         ST_IDLE: begin
            if (if_elig || dm_elig) begin
               last_gnt_d = gnt;
               en_d       = 1'b1;
               cnt_clr    = 1'b1;
               if (gnt == GNT_DM) begin
                  state_d = ST_DM_ACC;
                  rw_d    = dm_rw;
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
                  size_d  = dm_size;
                  se_d    = dm_se;
               end else begin
                  state_d = ST_IF_ACC;
                  rw_d    = ~RW_WRITE;
                  addr_d  = if_addr;
                  size_d  = SIZE_WORD;
                  se_d    = 1'b0;
               end
            end
         end
         ST_IF_ACC, ST_DM_ACC: begin
            if (cnt_done) begin
               en_d    = 1'b0;
               state_d = ST_IDLE;
               if (state_q == ST_IF_ACC) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  dm_valid_d = 1'b1;
                  if (rw_q != RW_WRITE) dm_rdata_d = mem_rdata;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (R) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= GNT_IF;
         en_q       <= 1'b0;
         rw_q       <= 1'b0;
         se_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= SIZE_BYTE;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         en_q       <= en_d;
         rw_q       <= rw_d;
         se_q       <= se_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         if_valid_q <= if_valid_d;
         dm_valid_q <= dm_valid_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign mem_en    = en_q;
   assign mem_rw    = rw_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_size  = size_q;
   assign mem_se    = se_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = dm_req & ~dm_valid_q;

endmodule
